// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the scoreboarded register file.
// It holds the sweep/run state encoding and the default geometry.
package reg_file_sb_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_REG_NUM = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/reg_file_sb_score.sv
// Busy-bit scoreboard. Issue sets a bit, writeback clears it, and flush clears everything.
// Priority is flush over set, and set over clear. The count output is a registered popcount.
module reg_file_sb_score
    import reg_file_sb_pkg::*;
#(
    parameter int  REG_NUM = DEF_REG_NUM,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               set_vld,
    input  logic [AW-1:0]      set_idx,
    input  logic               clr_vld,
    input  logic [AW-1:0]      clr_idx,
    input  logic               flush,
    output logic [REG_NUM-1:0] busy,
    output logic [AW-1:0]      busy_cnt
);

    logic [REG_NUM-1:0] busy_nxt;
    logic [AW-1:0]      cnt_nxt;

    // Register 0 can never become busy, so the count tops out at REG_NUM-1 and fits AW bits.
    always_comb begin
        busy_nxt = busy;
        if (en) begin
            if (clr_vld && (clr_idx != '0)) busy_nxt[clr_idx] = 1'b0;
            if (set_vld && (set_idx != '0)) busy_nxt[set_idx] = 1'b1;
            if (flush)                      busy_nxt          = '0;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            cnt_nxt = cnt_nxt + AW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with a zero register, multiple combinational read ports, and a write-through bypass.
// It includes a busy scoreboard, and its storage is zeroed by a post-reset sweep.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int  XLEN    = DEF_XLEN,
    parameter int  REG_NUM = DEF_REG_NUM,
    parameter int  NUM_RD  = 2,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   ra,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rbusy,
    input  logic [AW-1:0]          wa,
    input  logic [XLEN-1:0]        wd,
    input  logic                   reg_wr,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_rd,
    input  logic                   flush,
    output logic                   init_done,
    output logic [AW-1:0]          busy_cnt,
    output logic                   dbg_state
);

    state_e             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               run;
    logic               mem_we;
    logic [AW-1:0]      mem_wa;
    logic [XLEN-1:0]    mem_wd;
    logic [XLEN-1:0]    mem [REG_NUM];
    logic [REG_NUM-1:0] busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The single storage write port is shared by the sweep (INIT) and writeback (RUN).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_we  = 1'b0;
        mem_wa  = wa;
        mem_wd  = wd;
        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                mem_wa = idx_q;
                mem_wd = '0;
                idx_d  = idx_q + AW'(1);
                if (idx_q == AW'(REG_NUM - 1)) state_d = RUN;
            end
            RUN: begin
                mem_we = reg_wr && (wa != '0);
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Storage has no reset; the sweep clears it instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign run       = (state_q == RUN);
    assign init_done = run;
    assign dbg_state = state_q;

    reg_file_sb_score #(
        .REG_NUM (REG_NUM)
    ) u_score (
        .clk      (clk),
        .rst      (rst),
        .en       (run),
        .set_vld  (iss_valid),
        .set_idx  (iss_rd),
        .clr_vld  (reg_wr),
        .clr_idx  (wa),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = ra[i*AW +: AW];
        assign hit  = reg_wr && (wa == addr);

        // A same-cycle writeback both forwards its data and hides the busy bit it is about to clear.
        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (run && (addr != '0)) begin
                data = hit ? wd : mem[addr];
                bsy  = busy[addr] && !hit;
            end
        end

        assign rdata[i*XLEN +: XLEN] = data;
        assign rbusy[i]              = bsy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a behavioural model is compared on every cycle,
// together with directed literal checks for the reset sweep, bypass, and scoreboard corners.
module tb_reg_file_sb;

    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;
    localparam int NUM_RD  = 2;
    localparam int AW      = $clog2(REG_NUM);

    logic                   clk       = 1'b0;
    logic                   rst       = 1'b0;
    logic [NUM_RD*AW-1:0]   ra        = '0;
    logic [NUM_RD*XLEN-1:0] rdata;
    logic [NUM_RD-1:0]      rbusy;
    logic [AW-1:0]          wa        = '0;
    logic [XLEN-1:0]        wd        = '0;
    logic                   reg_wr    = 1'b0;
    logic                   iss_valid = 1'b0;
    logic [AW-1:0]          iss_rd    = '0;
    logic                   flush     = 1'b0;
    logic                   init_done;
    logic [AW-1:0]          busy_cnt;
    logic                   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [XLEN-1:0] m_mem  [REG_NUM];
    bit              m_busy [REG_NUM];
    bit              m_run;
    int              m_init_cnt;

    reg_file_sb #(
        .XLEN    (XLEN),
        .REG_NUM (REG_NUM),
        .NUM_RD  (NUM_RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ra        (ra),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .wa        (wa),
        .wd        (wd),
        .reg_wr    (reg_wr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .init_done (init_done),
        .busy_cnt  (busy_cnt),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run      = 1'b0;
        m_init_cnt = 0;
        for (int r = 0; r < REG_NUM; r++) m_busy[r] = 1'b0;
    endtask

    task automatic model_step();
        if (!m_run) begin
            m_init_cnt++;
            if (m_init_cnt == REG_NUM - 1) begin
                m_run = 1'b1;
                for (int r = 0; r < REG_NUM; r++) m_mem[r] = '0;
            end
        end else begin
            if (reg_wr && wa != 0) begin
                m_mem[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            if (flush) for (int r = 0; r < REG_NUM; r++) m_busy[r] = 1'b0;
        end
    endtask

    // Per-cycle compare against the model; inputs are stable at the falling edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) model_reset();
            begin
                int               cnt;
                logic [AW-1:0]    a;
                logic [XLEN-1:0]  exp_d;
                logic             exp_b;
                bit               hit;
                cnt = 0;
                for (int r = 0; r < REG_NUM; r++) cnt += int'(m_busy[r]);
                check("m_init_done", 32'(init_done), 32'(m_run));
                check("m_dbg_state", 32'(dbg_state), 32'(m_run));
                check("m_busy_cnt", 32'(busy_cnt), 32'(cnt));
                for (int i = 0; i < NUM_RD; i++) begin
                    a     = ra[i*AW +: AW];
                    hit   = reg_wr && (wa == a);
                    exp_d = '0;
                    exp_b = 1'b0;
                    if (m_run && a != 0) begin
                        exp_d = hit ? wd : m_mem[a];
                        exp_b = m_busy[a] && !hit;
                    end
                    check($sformatf("m_rdata%0d_a%0d", i, a), rdata[i*XLEN +: XLEN], exp_d);
                    check($sformatf("m_rbusy%0d_a%0d", i, a), 32'(rbusy[i]), 32'(exp_b));
                end
            end
            @(posedge clk);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_wr    = 1'b0;
        iss_valid = 1'b0;
        flush     = 1'b0;
        wa        = '0;
        wd        = '0;
        iss_rd    = '0;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
    endtask

    function automatic logic [XLEN-1:0] rd(input int p);
        return rdata[p*XLEN +: XLEN];
    endfunction

    task automatic randomize_inputs(input int flush_odds);
        reg_wr    = 1'($urandom_range(0, 1));
        wa        = AW'($urandom_range(0, REG_NUM - 1));
        wd        = $urandom;
        iss_valid = 1'($urandom_range(0, 1));
        iss_rd    = AW'($urandom_range(0, REG_NUM - 1));
        flush     = ($urandom_range(0, flush_odds - 1) == 0);
        ra        = (NUM_RD*AW)'($urandom);
    endtask

    // Called just after rst deasserts; junk traffic is driven throughout INIT.
    task automatic do_sweep(input string tag);
        logic [AW-1:0] junk_wa;
        junk_wa = AW'($urandom_range(1, REG_NUM - 1));
        for (int k = 1; k <= REG_NUM - 1; k++) begin
            tick();
            if (k < REG_NUM - 1) begin
                randomize_inputs(4);
                reg_wr = 1'b1;
                wa     = junk_wa;
                wd     = 32'hBAD0_0000 | 32'(k);
            end else begin
                idle();
                set_ra(0, junk_wa);
            end
            #2;
            if (k == 15)          check({tag, "_rdata_mid_sweep"}, rd(0), 32'h0);
            if (k == REG_NUM - 2) check({tag, "_init_done_c30"}, 32'(init_done), 32'h0);
            if (k == REG_NUM - 1) begin
                check({tag, "_init_done_c31"}, 32'(init_done), 32'h1);
                check({tag, "_init_write_dropped"}, rd(0), 32'h0);
            end
        end
    endtask

    initial begin
        idle();
        repeat (3) tick();
        check("reset_init_done", 32'(init_done), 32'h0);
        check("reset_busy_cnt", 32'(busy_cnt), 32'h0);
        rst = 1'b1;
        do_sweep("sweep1");

        // Write-through bypass and zero register
        tick(); reg_wr = 1'b1; wa = 5; wd = 32'hDEAD_BEEF; set_ra(0, 5); #2;
        check("bypass_x5", rd(0), 32'hDEAD_BEEF);
        tick(); idle(); #2;
        check("stored_x5", rd(0), 32'hDEAD_BEEF);
        tick(); reg_wr = 1'b1; wa = 0; wd = 32'h1234; set_ra(0, 0); #2;
        check("x0_bypass", rd(0), 32'h0);
        tick(); idle(); #2;
        check("x0_stored", rd(0), 32'h0);

        // Issue then writeback
        tick(); iss_valid = 1'b1; iss_rd = 7;
        tick(); idle(); set_ra(1, 7); #2;
        check("iss7_rbusy1", 32'(rbusy[1]), 32'h1);
        check("iss7_cnt", 32'(busy_cnt), 32'h1);
        tick(); reg_wr = 1'b1; wa = 7; wd = 32'hCAFE_0007; #2;
        check("wb7_rbusy1", 32'(rbusy[1]), 32'h0);
        check("wb7_rdata1", rd(1), 32'hCAFE_0007);
        check("wb7_cnt_same", 32'(busy_cnt), 32'h1);
        tick(); idle(); #2;
        check("wb7_cnt_next", 32'(busy_cnt), 32'h0);

        // Set wins over clear; flush wins over set
        tick(); iss_valid = 1'b1; iss_rd = 9;
        tick(); iss_valid = 1'b1; iss_rd = 9; reg_wr = 1'b1; wa = 9; wd = 32'h1111_0009; set_ra(1, 9);
        tick(); idle(); #2;
        check("set_wins_rbusy", 32'(rbusy[1]), 32'h1);
        check("set_wins_cnt", 32'(busy_cnt), 32'h1);
        tick(); iss_valid = 1'b1; iss_rd = 9; reg_wr = 1'b1; wa = 9; wd = 32'h2222_0009; flush = 1'b1;
        tick(); idle(); #2;
        check("flush_wins_rbusy", 32'(rbusy[1]), 32'h0);
        check("flush_wins_cnt", 32'(busy_cnt), 32'h0);
        check("flush_wr_stored", rd(1), 32'h2222_0009);

        // Fill the scoreboard
        for (int r = 1; r < REG_NUM; r++) begin
            tick(); iss_valid = 1'b1; iss_rd = AW'(r);
        end
        tick(); iss_valid = 1'b1; iss_rd = 0; #2;
        check("all_busy_cnt", 32'(busy_cnt), 32'd31);
        tick(); idle(); flush = 1'b1; #2;
        check("iss_x0_cnt", 32'(busy_cnt), 32'd31);
        tick(); idle(); #2;
        check("flush_all_cnt", 32'(busy_cnt), 32'h0);

        // Random traffic
        repeat (1500) begin
            tick();
            randomize_inputs(32);
        end
        tick(); idle();

        // Mid-RUN reset, then reset again at sweep index 10
        rst = 1'b0; #2;
        check("runrst_init_done", 32'(init_done), 32'h0);
        check("runrst_busy_cnt", 32'(busy_cnt), 32'h0);
        tick(); tick(); rst = 1'b1;
        repeat (9) tick();
        rst = 1'b0; #2;
        check("sweeprst_init_done", 32'(init_done), 32'h0);
        tick(); rst = 1'b1;
        do_sweep("sweep2");

        repeat (300) begin
            tick();
            randomize_inputs(32);
        end
        tick(); idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
